// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake
// and queues up to two {pc+4, instr} bundles for IF/ID. Optional IF_PERF_CNT_EN enables the pop counter.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [63:0] out_bundle,
    output logic        if_flush,
    output logic [31:0] perf_fetch_cnt
);

    typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fetch_entry_t;

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt;
    logic [31:0]      drain_addr, drain_addr_nxt;
    logic [31:0]      target;
    fetch_entry_t [1:0] q;
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count, count_nxt;
    logic             push, pop;

    assign target = {redirect_pc[31:2], 2'b00};

    // Queue handshakes; rst gating keeps the reset cycle quiet even before registers clear.
    assign out_valid  = !rst && (count != 2'd0);
    assign out_bundle = out_valid ? q[rd_ptr] : 64'd0;
    assign if_flush   = redirect && !rst;
    assign push       = !rst && (state == S_FETCH) && imem_ready && !redirect;
    assign pop        = out_valid && !stall && !redirect;

    always_comb begin
        if (redirect)
            count_nxt = 2'd0;
        else
            count_nxt = count + {1'b0, push} - {1'b0, pop};
    end

    // State register plus PC and drain address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            drain_addr <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
        end
    end

    // Next-state logic; redirect wins over everything else.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        unique case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_nxt = target;
                    if (!imem_ready) begin
                        drain_addr_nxt = pc;
                        state_nxt      = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_nxt = pc + 32'd4;
                    if (count_nxt == 2'd2)
                        state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_FETCH;
                end else if (pop) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The abandoned request must still complete before a new one can go out.
                if (redirect)
                    pc_nxt = target;
                else if (imem_ready)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (!rst) begin
            unique case (state)
                S_FETCH: imem_req = 1'b1;
                S_DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = drain_addr;
                end
                default: imem_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count_nxt;
            if (push) begin
                q[wr_ptr] <= '{pc4: pc + 32'd4, instr: imem_rdata};
                wr_ptr    <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            perf_cnt <= 32'd0;
        else if (pop)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_fetch_cnt = perf_cnt;
`else
    assign perf_fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory returns addr ^ KEY, expected bundles hand-derived per cycle.
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'h5A5A_0000;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, out_valid, if_flush;
    logic [31:0] imem_addr, imem_rdata, perf_fetch_cnt;
    logic [63:0] out_bundle;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ KEY;

    if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_bundle(out_bundle), .if_flush(if_flush), .perf_fetch_cnt(perf_fetch_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bundle(input logic [31:0] addr);
        logic [31:0] pc4;
        pc4 = addr + 32'd4;
        return {pc4, addr ^ KEY};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; redirect_pc = 32'd0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        // Reset cycle outputs, including flush suppression
        rst = 1'b1; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h44; imem_ready = 1'b1;
        tick;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_bundle", out_bundle, 0);
        chk("rst_flush", if_flush, 0);
        redirect = 1'b0;
        tick;

        // Zero-wait stream
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        chk("zw_addr0", imem_addr, 32'h100);
        chk("zw_req0", imem_req, 1);
        chk("zw_vld0", out_valid, 0);
        chk("zw_perf0", perf_fetch_cnt, 0);
        tick;
        chk("zw_b1", out_bundle, bundle(32'h100));
        tick;
        chk("zw_b2", out_bundle, bundle(32'h104));
        tick;
        chk("zw_b3", out_bundle, bundle(32'h108));
        chk("zw_perf3", perf_fetch_cnt, PERF ? 32'd2 : 32'd0);

        // Wait states: ready every third cycle
        do_reset;
        for (int c = 0; c < 9; c++) begin
            imem_ready = (c % 3 == 2);
            #1;
            chk("ws_addr", imem_addr, 32'h100 + 32'(4 * (c / 3)));
            chk("ws_vld", out_valid, (c % 3 == 0) && (c > 0));
            if ((c % 3 == 0) && (c > 0))
                chk("ws_data", out_bundle, bundle(32'h100 + 32'(4 * (c / 3 - 1))));
            tick;
        end

        // Stall fill from empty queue
        do_reset;
        imem_ready = 1'b1; stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("sf_req", imem_req, c < 2);
            tick;
        end
        stall = 1'b0;
        #1;
        chk("sf_req5", imem_req, 0);
        chk("sf_b5", out_bundle, bundle(32'h100));
        tick;
        chk("sf_b6", out_bundle, bundle(32'h104));
        chk("sf_addr6", imem_addr, 32'h108);
        chk("sf_req6", imem_req, 1);
        tick;
        chk("sf_b7", out_bundle, bundle(32'h108));

        // Redirect mid-request
        do_reset;
        imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("rm_flush0", if_flush, 1);
        tick;
        redirect = 1'b0; imem_ready = 1'b0;
        #1;
        chk("rm_addr1", imem_addr, 32'h40);
        chk("rm_vld1", out_valid, 0);
        tick;
        redirect = 1'b1; redirect_pc = 32'h2002;
        #1;
        chk("rm_flush2", if_flush, 1);
        tick;
        redirect = 1'b0;
        #1;
        chk("rm_drain_req", imem_req, 1);
        chk("rm_drain_addr", imem_addr, 32'h40);
        chk("rm_vld3", out_valid, 0);
        tick;
        imem_ready = 1'b1;
        #1;
        chk("rm_drain_addr4", imem_addr, 32'h40);
        tick;
        chk("rm_addr5", imem_addr, 32'h2000);
        chk("rm_vld5", out_valid, 0);
        tick;
        chk("rm_b6", out_bundle, bundle(32'h2000));

        // Redirect with stall and full queue
        do_reset;
        imem_ready = 1'b1; stall = 1'b1;
        tick;
        tick;
        redirect = 1'b1; redirect_pc = 32'h3000;
        #1;
        chk("rf_flush", if_flush, 1);
        chk("rf_vld", out_valid, 1);
        chk("rf_req", imem_req, 0);
        chk("rf_head", out_bundle, bundle(32'h100));
        tick;
        redirect = 1'b0; stall = 1'b0;
        #1;
        chk("rf_empty", out_valid, 0);
        chk("rf_addr", imem_addr, 32'h3000);
        chk("rf_perf", perf_fetch_cnt, 0);
        tick;
        chk("rf_b", out_bundle, bundle(32'h3000));

        // PC wrap, then reset during drain
        do_reset;
        imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect = 1'b0;
        #1;
        chk("wr_addr1", imem_addr, 32'hFFFF_FFFC);
        tick;
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
        #1;
        chk("wr_addr2", imem_addr, 32'h0);
        chk("wr_b2", out_bundle, bundle(32'hFFFF_FFFC));
        tick;
        redirect = 1'b0;
        #1;
        chk("wr_drain", imem_addr, 32'h0);
        rst = 1'b1;
        #1;
        chk("wr_rst_req", imem_req, 0);
        chk("wr_rst_vld", out_valid, 0);
        tick;
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        chk("wr_restart_addr", imem_addr, 32'h100);
        chk("wr_restart_req", imem_req, 1);
        chk("wr_restart_vld", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
